// File: rtl/hp_au.sv
// hp_au: single-cycle-latency arithmetic/logic unit.
// A 4-bit opcode selects one of 16 operations on WIDTH-bit operands. The result and
// {Z, N, C, V} flags are registered whenever in_valid is high and held otherwise.
// Optional feature macro HP_AU_MULHI_EN: when defined, slot 9 (MULH) returns the upper
// WIDTH bits of a*b. When undefined, slot 9 returns 0 with all flags clear.

module hp_au #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic [3:0]       flags
);

    localparam int unsigned Msb = WIDTH - 1;
    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    typedef enum logic [3:0] {
        OpAdd   = 4'd0,
        OpSub   = 4'd1,
        OpInc   = 4'd2,
        OpDec   = 4'd3,
        OpAnd   = 4'd4,
        OpOr    = 4'd5,
        OpXor   = 4'd6,
        OpNot   = 4'd7,
        OpMul   = 4'd8,
        OpMulh  = 4'd9,
        OpShl   = 4'd10,
        OpShr   = 4'd11,
        OpAsr   = 4'd12,
        OpRol   = 4'd13,
        OpPassb = 4'd14,
        OpCmp   = 4'd15
    } op_e;

    logic [WIDTH-1:0]   result_q;
    logic [3:0]         flags_q;
    logic               out_valid_q;

    // INC/DEC reuse the adder/subtractor with a constant second operand.
    logic               use_one;
    logic [WIDTH-1:0]   opnd_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic               add_v;
    logic               sub_v;
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_z;
    logic               alu_n;
    logic               alu_c;
    logic               alu_v;

    assign use_one = (sel == OpInc) || (sel == OpDec);
    assign opnd_b  = use_one ? One : b;
    assign sum     = {1'b0, a} + {1'b0, opnd_b};
    assign diff    = {1'b0, a} - {1'b0, opnd_b};
    // Signed overflow: operands agree in sign (add) or differ (sub) and result sign flips.
    assign add_v   = (a[Msb] == opnd_b[Msb]) && (sum[Msb] != a[Msb]);
    assign sub_v   = (a[Msb] != opnd_b[Msb]) && (diff[Msb] != a[Msb]);
    assign prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Operation decode: result, carry/borrow and overflow, then Z/N with per-slot overrides.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (sel)
            OpAdd, OpInc: begin
                alu_res = sum[Msb:0];
                alu_c   = sum[WIDTH];
                alu_v   = add_v;
            end
            OpSub, OpDec, OpCmp: begin
                alu_res = (sel == OpCmp) ? '0 : diff[Msb:0];
                alu_c   = diff[WIDTH];
                alu_v   = sub_v;
            end
            OpAnd:   alu_res = a & b;
            OpOr:    alu_res = a | b;
            OpXor:   alu_res = a ^ b;
            OpNot:   alu_res = ~a;
            OpMul: begin
                alu_res = prod[Msb:0];
                alu_c   = |prod[2*WIDTH-1:WIDTH];
            end
            OpMulh: begin
`ifdef HP_AU_MULHI_EN
                alu_res = prod[2*WIDTH-1:WIDTH];
`else
                alu_res = '0;
`endif
            end
            OpShl: begin
                alu_res = {a[Msb-1:0], 1'b0};
                alu_c   = a[Msb];
            end
            OpShr: begin
                alu_res = {1'b0, a[Msb:1]};
                alu_c   = a[0];
            end
            OpAsr: begin
                alu_res = {a[Msb], a[Msb:1]};
                alu_c   = a[0];
            end
            OpRol:   alu_res = {a[Msb-1:0], a[Msb]};
            OpPassb: alu_res = b;
            default: alu_res = '0;
        endcase

        alu_z = (alu_res == '0);
        alu_n = alu_res[Msb];
        if (sel == OpCmp) begin
            // Compare reports on a-b even though the visible result is zero.
            alu_z = (diff[Msb:0] == '0);
            alu_n = diff[Msb];
        end
`ifndef HP_AU_MULHI_EN
        if (sel == OpMulh) begin
            alu_z = 1'b0;
            alu_n = 1'b0;
        end
`endif
    end

    // Output registers: load on in_valid, hold otherwise; out_valid tracks in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                result_q <= alu_res;
                flags_q  <= {alu_z, alu_n, alu_c, alu_v};
            end
        end
    end

    assign result    = result_q;
    assign flags     = flags_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_hp_au.sv
// Self-checking bench for hp_au (WIDTH=4): reset, a vector table streamed back-to-back
// through a scoreboard queue, idle hold, and asynchronous reset mid-operation.

module tb_hp_au;

    localparam int unsigned W = 4;
    localparam int unsigned NVec = 23;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   sel;
    logic [W-1:0] result;
    logic         out_valid;
    logic [3:0]   flags;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   sel;
        logic [W-1:0] res;
        logic [3:0]   flg;   // {Z, N, C, V}
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;
    } exp_t;

    vec_t vecs [NVec];
    exp_t exp_q [$];

    int n_checks;
    int n_pass;

    hp_au #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .result    (result),
        .out_valid (out_valid),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic set_vec(input int i, input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic [3:0] vs, input logic [W-1:0] vr,
                           input logic [3:0] vf);
        vecs[i].a   = va;
        vecs[i].b   = vb;
        vecs[i].sel = vs;
        vecs[i].res = vr;
        vecs[i].flg = vf;
    endtask

    // Scoreboard monitor: every out_valid must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("stream_result", 32'(result), 32'(e.res));
                check("stream_flags", 32'(flags), 32'(e.flg));
            end
        end
    end

    initial begin
        exp_t last;
        int   wait_cycles;

        n_checks = 0;
        n_pass   = 0;

        //            a        b        sel    res      {Z,N,C,V}
        set_vec(0,  4'b1100, 4'b1010, 4'd4,  4'b1000, 4'b0100); // AND
        set_vec(1,  4'd3,    4'd2,    4'd8,  4'd6,    4'b0000); // MUL
        set_vec(2,  4'd4,    4'd4,    4'd8,  4'd0,    4'b1010); // MUL truncation
        set_vec(3,  4'd15,   4'd1,    4'd0,  4'd0,    4'b1010); // ADD wrap
        set_vec(4,  4'd7,    4'd1,    4'd0,  4'd8,    4'b0101); // ADD overflow
        set_vec(5,  4'd0,    4'd1,    4'd1,  4'd15,   4'b0110); // SUB borrow
        set_vec(6,  4'd5,    4'd5,    4'd15, 4'd0,    4'b1000); // CMP equal
        set_vec(7,  4'd15,   4'd3,    4'd2,  4'd0,    4'b1010); // INC wrap
        set_vec(8,  4'd0,    4'd9,    4'd3,  4'd15,   4'b0110); // DEC borrow
        set_vec(9,  4'd8,    4'd0,    4'd3,  4'd7,    4'b0001); // DEC overflow
        set_vec(10, 4'b0101, 4'b0010, 4'd5,  4'b0111, 4'b0000); // OR
        set_vec(11, 4'b1111, 4'b1111, 4'd6,  4'b0000, 4'b1000); // XOR
        set_vec(12, 4'b0000, 4'b0110, 4'd7,  4'b1111, 4'b0100); // NOT
        set_vec(13, 4'b1001, 4'd0,    4'd10, 4'b0010, 4'b0010); // SHL
        set_vec(14, 4'b1001, 4'd0,    4'd11, 4'b0100, 4'b0010); // SHR
        set_vec(15, 4'b1000, 4'd0,    4'd12, 4'b1100, 4'b0100); // ASR
        set_vec(16, 4'b1001, 4'd0,    4'd13, 4'b0011, 4'b0000); // ROL
        set_vec(17, 4'd0,    4'b1010, 4'd14, 4'b1010, 4'b0100); // PASSB
        set_vec(18, 4'd3,    4'd5,    4'd15, 4'd0,    4'b0110); // CMP less
        set_vec(19, 4'd8,    4'd1,    4'd1,  4'd7,    4'b0001); // SUB overflow
`ifdef HP_AU_MULHI_EN
        set_vec(20, 4'd15,   4'd15,   4'd9,  4'd14,   4'b0100); // MULH
`else
        set_vec(20, 4'd15,   4'd15,   4'd9,  4'd0,    4'b0000); // MULH disabled
`endif
        set_vec(21, 4'd15,   4'd15,   4'd8,  4'd1,    4'b0010); // MUL high discard
        set_vec(22, 4'd8,    4'd8,    4'd0,  4'd0,    4'b1011); // ADD neg overflow

        // Reset held with random valid inputs: outputs stay cleared.
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        sel      = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_result", 32'(result), 32'd0);
            check("reset_flags", 32'(flags), 32'd0);
            check("reset_out_valid", 32'(out_valid), 32'd0);
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
            sel      = 4'($urandom);
        end

        // Release with in_valid low: outputs unchanged until the first operation.
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_result", 32'(result), 32'd0);
        check("post_reset_flags", 32'(flags), 32'd0);
        check("post_reset_out_valid", 32'(out_valid), 32'd0);

        // Stream the table back-to-back, one operation per cycle.
        for (int i = 0; i < NVec; i++) begin
            exp_t e;
            in_valid = 1'b1;
            a        = vecs[i].a;
            b        = vecs[i].b;
            sel      = vecs[i].sel;
            e.res    = vecs[i].res;
            e.flg    = vecs[i].flg;
            exp_q.push_back(e);
            @(negedge clk);
        end
        last.res = vecs[NVec-1].res;
        last.flg = vecs[NVec-1].flg;

        // Idle: drop in_valid with fresh operands; result and flags must hold.
        in_valid = 1'b0;
        a        = 4'd1;
        b        = 4'd2;
        sel      = 4'd0;
        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("idle_out_valid", 32'(out_valid), 32'd0);
            check("idle_result_hold", 32'(result), 32'(last.res));
            check("idle_flags_hold", 32'(flags), 32'(last.flg));
        end

        // Single op then idle, to leave a non-zero result visible.
        in_valid = 1'b1;
        a        = 4'd6;
        b        = 4'd3;
        sel      = 4'd0;
        last.res = 4'd9;
        last.flg = 4'b0101;
        exp_q.push_back(last);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("single_op_drained", 32'(exp_q.size()), 32'd0);
        check("single_op_hold", 32'(result), 32'd9);

        // Asynchronous reset with an operation in flight: cleared immediately and discarded.
        in_valid = 1'b1;
        a        = 4'd7;
        b        = 4'd7;
        sel      = 4'd6;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_result", 32'(result), 32'd0);
        check("async_reset_flags", 32'(flags), 32'd0);
        check("async_reset_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("reset_discard_out_valid", 32'(out_valid), 32'd0);
        check("reset_discard_result", 32'(result), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("after_reset_out_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hp_au.md
Name: hp_au

Overview:
- Parameterised, single-cycle-latency arithmetic/logic unit ("HP-AU").
- Selects one of 16 operation slots via a 4-bit opcode and registers a WIDTH-bit result plus status flags.
- Datapath leaf block: an upstream sequencer drives a, b and sel with in_valid; downstream logic samples result when out_valid is high.

Parameters:
- WIDTH, 4, operand and result width in bits (legal: 2 to 32).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and opcode are valid this cycle
- a  in  WIDTH  operand A (unsigned; signed view for overflow/ASR)
- b  in  WIDTH  operand B
- sel  in  4  operation slot
- result  out  WIDTH  registered operation result
- out_valid  out  1  result/flags hold a new value this cycle
- flags  out  4  {Z, N, C, V} registered status: zero, negative (MSB), carry/borrow, signed overflow

Behaviour:
- Reset is asserted asynchronously (rst_n=0) and released synchronously to clk. While in reset: result=0, flags=0, out_valid=0.
- Latency:
  - in_valid=1 at edge k: result, flags and out_valid=1 appear after edge k and hold until edge k+1.
  - in_valid=0: out_valid=0 next cycle; result and flags hold their previous values.
  - No back-pressure; a new operation is accepted every cycle.
- Opcode map (all results truncated to the low WIDTH bits):
  - 0 ADD: a+b; C=carry out; V=signed overflow.
  - 1 SUB: a-b; C=borrow (a<b unsigned); V=signed overflow.
  - 2 INC: a+1; C, V as ADD.
  - 3 DEC: a-1; C, V as SUB.
  - 4 AND: a&b.
  - 5 OR: a|b.
  - 6 XOR: a^b.
  - 7 NOT: ~a.
  - 8 MUL: low WIDTH bits of the 2*WIDTH product a*b; C=1 if the discarded upper half is non-zero.
  - 9 MULH: see Optional Feature.
  - 10 SHL: a<<1; C=a[MSB].
  - 11 SHR: logical a>>1; C=a[0].
  - 12 ASR: arithmetic a>>>1; C=a[0].
  - 13 ROL: rotate a left by 1.
  - 14 PASSB: b.
  - 15 CMP: result=0; flags as SUB (a-b); intended for compare-only use.
- Flag rules:
  - Z=1 iff the registered result is 0. For CMP, Z=1 iff a==b.
  - N=result[WIDTH-1]. For CMP, N is the MSB of a-b.
  - C and V are 0 for every slot not listed above as setting them.
- Boundary cases (WIDTH=4):
  - 15+1 -> 0, C=1, Z=1.
  - 0-1 -> 15, C=1.
  - 7+1 -> 8, V=1.
  - 4*4=16 -> 0, C=1, Z=1.
- Reset asserted mid-operation discards the in-flight operation; outputs go to 0 immediately.
- Combinational path from inputs to the output registers only; no combinational input-to-output path.

Optional Feature:
- Macro: HP_AU_MULHI_EN.
- When defined, slot 9 (MULH) returns the upper WIDTH bits of a*b, with C=0 and V=0.
- When undefined, slot 9 returns 0 with all flags 0, and no multiplier upper-half logic is kept beyond what MUL's carry needs.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> result=0, flags=0, out_valid=0. Release rst_n -> outputs unchanged until the first in_valid.
- AND regression: a=4'b1100, b=4'b1010, sel=4, in_valid=1 -> next cycle result=4'b1000, Z=0, N=1, out_valid=1.
- MUL: a=3, b=2, sel=8 -> result=6, C=0.
- MUL truncation: a=4, b=4, sel=8 -> result=0, Z=1, C=1.
- ADD/SUB edges:
  - 15+1 (sel=0) -> result=0, C=1, Z=1.
  - 7+1 (sel=0) -> result=8, V=1.
  - 0-1 (sel=1) -> result=15, C=1.
  - CMP 5,5 (sel=15) -> result=0, Z=1.
- Streaming and idle: back-to-back valid ops on consecutive cycles -> one result per cycle. Drop in_valid -> out_valid=0 and result held. With HP_AU_MULHI_EN defined, a=15, b=15, sel=9 -> result=14; without the macro -> result=0.
